// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
// Holds the sequencer state enum, the minutes-per-day bound and default widths.
package alarm_pkg;

  localparam int unsigned MINUTES_PER_DAY = 1440;
  localparam int unsigned TIME_W          = 11;
  localparam int unsigned CNT_W           = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/alarm_sequencer_tick_counter.sv
// Loadable terminal-count tick counter, shared by the snooze and ring-timeout intervals.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : return the count to zero (wins over tick)
//   tick         : advance the count by one
//   limit        : interval length in ticks
//   done         : combinational, high when tick arrives on the last count of the interval
module tick_counter #(
  parameter int unsigned CNT_W = alarm_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  assign done = tick && (r_count == (limit - CNT_W'(1)));

  // Wraps to zero on the terminal tick so a held interval restarts cleanly.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= done ? '0 : (r_count + CNT_W'(1));
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: holds the alarm time, detects the minute crossing onto it and
// sequences ringing, snooze and ring-timeout; drives buzzer and blink controls.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   tick                  : 1 Hz single-cycle pulse
//   cur_time              : current minutes-of-day
//   set_valid, set_time   : alarm time load request
//   arm                   : alarm enable level
//   snooze, stop          : debounced single-cycle button pulses
//   alarm_time            : programmed alarm time
//   buzzer_en, blink      : buzzer and display blink controls
//   armed                 : high in any state other than IDLE
//   snooze_cnt            : snoozes used in the current alarm event
//   set_err               : single-cycle pulse on a rejected load
module alarm_sequencer #(
  parameter int unsigned TIME_W           = alarm_pkg::TIME_W,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned MAX_SNOOZES      = 3,
  parameter int unsigned CNT_W            = alarm_pkg::CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              set_valid,
  input  logic [TIME_W-1:0] set_time,
  input  logic              arm,
  input  logic              snooze,
  input  logic              stop,
  output logic [TIME_W-1:0] alarm_time,
  output logic              buzzer_en,
  output logic              blink,
  output logic              armed,
  output logic [1:0]        snooze_cnt,
  output logic              set_err
);

  import alarm_pkg::*;

  alarm_state_t      r_state, w_state_nxt;
  logic [TIME_W-1:0] r_alarm_time, r_last_time, w_alarm_nxt;
  logic              r_buzzer_en, r_blink, r_armed, r_set_err;
  logic [1:0]        r_snooze_cnt, w_snooze_cnt_nxt;
  logic              w_blink_nxt, w_set_err_nxt;
  logic              w_trigger, w_in_alert, w_cnt_tick, w_cnt_clear, w_cnt_done;
  logic [CNT_W-1:0]  w_limit;

  // Fires only on the cycle cur_time steps onto the alarm minute.
  assign w_trigger  = (cur_time != r_last_time) && (cur_time == r_alarm_time);
  assign w_in_alert = (r_state == RINGING) || (r_state == SNOOZE);
  assign w_limit    = (r_state == RINGING) ? CNT_W'(RING_TIMEOUT_SEC) : CNT_W'(SNOOZE_SEC);
  assign w_cnt_tick = tick && w_in_alert;
  // Any state change starts the next interval from zero.
  assign w_cnt_clear = (w_state_nxt != r_state) || !w_in_alert;

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clock (clock),
    .reset (reset),
    .clear (w_cnt_clear),
    .tick  (w_cnt_tick),
    .limit (w_limit),
    .done  (w_cnt_done)
  );

  // Next state and next register values; priority arm=0 > stop > snooze > tick.
  always_comb begin
    w_state_nxt      = r_state;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_alarm_nxt      = r_alarm_time;
    w_set_err_nxt    = 1'b0;
    w_blink_nxt      = r_blink;

    if (!arm) begin
      w_state_nxt      = IDLE;
      w_snooze_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ARMED;
        ARMED: begin
          if (w_trigger) w_state_nxt = RINGING;
        end
        RINGING: begin
          if (stop) begin
            w_state_nxt      = ARMED;
            w_snooze_cnt_nxt = '0;
          end else if (snooze && (r_snooze_cnt < 2'(MAX_SNOOZES))) begin
            w_state_nxt      = SNOOZE;
            w_snooze_cnt_nxt = r_snooze_cnt + 2'(1);
          end else if (w_cnt_done) begin
            w_state_nxt      = ARMED;
            w_snooze_cnt_nxt = '0;
          end
        end
        SNOOZE: begin
          if (stop) begin
            w_state_nxt      = ARMED;
            w_snooze_cnt_nxt = '0;
          end else if (w_cnt_done) begin
            w_state_nxt = RINGING;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (set_valid) begin
      if ((set_time >= TIME_W'(MINUTES_PER_DAY)) || w_in_alert) begin
        w_set_err_nxt = 1'b1;
      end else begin
        w_alarm_nxt = set_time;
      end
    end

    if ((w_state_nxt == IDLE) || (w_state_nxt == ARMED)) begin
      w_blink_nxt = 1'b0;
    end else if (w_cnt_tick) begin
      w_blink_nxt = !r_blink;
    end
  end

  // State and output registers; status outputs follow the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_alarm_time <= '0;
      r_last_time  <= '0;
      r_buzzer_en  <= 1'b0;
      r_blink      <= 1'b0;
      r_armed      <= 1'b0;
      r_snooze_cnt <= '0;
      r_set_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_alarm_time <= w_alarm_nxt;
      r_last_time  <= cur_time;
      r_buzzer_en  <= (w_state_nxt == RINGING);
      r_blink      <= w_blink_nxt;
      r_armed      <= (w_state_nxt != IDLE);
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_set_err    <= w_set_err_nxt;
    end
  end

  assign alarm_time = r_alarm_time;
  assign buzzer_en  = r_buzzer_en;
  assign blink      = r_blink;
  assign armed      = r_armed;
  assign snooze_cnt = r_snooze_cnt;
  assign set_err    = r_set_err;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios plus randomized
// stimulus compared against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

  localparam int SNZ_SEC  = 3;
  localparam int RING_SEC = 5;
  localparam int MAX_SNZ  = 3;

  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_RING = 2;
  localparam int M_SNZ  = 3;

  logic        clock = 1'b0;
  logic        reset, tick, set_valid, arm, snooze, stop;
  logic [10:0] cur_time, set_time, alarm_time;
  logic        buzzer_en, blink, armed, set_err;
  logic [1:0]  snooze_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode, stored alarm, previous minute, elapsed seconds, snoozes used.
  int m_mode, m_alarm, m_last, m_secs, m_scnt;
  bit m_blink, m_serr;

  always #5 clock = ~clock;

  alarm_sequencer #(
    .TIME_W           (11),
    .SNOOZE_SEC       (SNZ_SEC),
    .RING_TIMEOUT_SEC (RING_SEC),
    .MAX_SNOOZES      (MAX_SNZ),
    .CNT_W            (9)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .cur_time   (cur_time),
    .set_valid  (set_valid),
    .set_time   (set_time),
    .arm        (arm),
    .snooze     (snooze),
    .stop       (stop),
    .alarm_time (alarm_time),
    .buzzer_en  (buzzer_en),
    .blink      (blink),
    .armed      (armed),
    .snooze_cnt (snooze_cnt),
    .set_err    (set_err)
  );

  // Applies one clock's worth of the alarm rules to the model using the current inputs.
  task automatic model_step();
    int old_mode;
    bit trig;
    if (reset) begin
      m_mode = M_OFF; m_alarm = 0; m_last = 0; m_secs = 0;
      m_scnt = 0; m_blink = 1'b0; m_serr = 1'b0;
      return;
    end
    old_mode = m_mode;
    trig = (int'(cur_time) != m_last) && (int'(cur_time) == m_alarm);
    m_serr = 1'b0;
    if (set_valid) begin
      if (set_time >= 11'd1440 || old_mode == M_RING || old_mode == M_SNZ) m_serr = 1'b1;
      else m_alarm = int'(set_time);
    end
    if (!arm) begin
      m_mode = M_OFF; m_secs = 0; m_scnt = 0;
    end else if (old_mode == M_OFF) begin
      m_mode = M_WAIT;
    end else if (old_mode == M_WAIT) begin
      if (trig) begin m_mode = M_RING; m_secs = 0; end
    end else if (stop) begin
      m_mode = M_WAIT; m_scnt = 0;
    end else if (old_mode == M_RING && snooze && m_scnt < MAX_SNZ) begin
      m_mode = M_SNZ; m_scnt = m_scnt + 1; m_secs = 0;
    end else if (tick) begin
      m_secs = m_secs + 1;
      if (old_mode == M_RING && m_secs == RING_SEC) begin
        m_mode = M_WAIT; m_scnt = 0;
      end else if (old_mode == M_SNZ && m_secs == SNZ_SEC) begin
        m_mode = M_RING; m_secs = 0;
      end
    end
    if (m_mode == M_OFF || m_mode == M_WAIT) m_blink = 1'b0;
    else if (tick && (old_mode == M_RING || old_mode == M_SNZ)) m_blink = !m_blink;
    m_last = int'(cur_time);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic pulses_off();
    set_valid = 1'b0; snooze = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; cur_time = 11'd0; set_time = 11'd0;
    pulses_off();
    step(); step();
    n_tests++;
    if ({alarm_time, buzzer_en, blink, armed, snooze_cnt, set_err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got alarm=%0d buz=%0b blink=%0b armed=%0b scnt=%0d err=%0b, expected all 0",
               alarm_time, buzzer_en, blink, armed, snooze_cnt, set_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_set_and_arm();
    cur_time = 11'd419; set_valid = 1'b1; set_time = 11'd420; arm = 1'b1;
    step(); pulses_off();
    n_tests++;
    if (alarm_time !== 11'd420 || armed !== 1'b1 || set_err !== 1'b0) begin
      n_fail++;
      $display("FAIL set_arm: got alarm=%0d armed=%0b err=%0b, expected 420 1 0", alarm_time, armed, set_err);
    end
    step();
    n_tests++;
    if (buzzer_en !== 1'b0) begin
      n_fail++; $display("FAIL pre_trigger_buzzer: got %0b expected 0", buzzer_en);
    end
    cur_time = 11'd420; step();
    n_tests++;
    if (buzzer_en !== 1'b1 || armed !== 1'b1) begin
      n_fail++; $display("FAIL trigger: got buz=%0b armed=%0b expected 1 1", buzzer_en, armed);
    end
    set_valid = 1'b1; set_time = 11'd1500; step(); pulses_off();
    n_tests++;
    if (set_err !== 1'b1 || alarm_time !== 11'd420) begin
      n_fail++; $display("FAIL bad_set: got err=%0b alarm=%0d expected 1 420", set_err, alarm_time);
    end
    step();
    n_tests++;
    if (set_err !== 1'b0) begin
      n_fail++; $display("FAIL set_err_pulse: got %0b expected 0", set_err);
    end
  endtask

  task automatic test_snooze_cycle();
    snooze = 1'b1; step(); pulses_off();
    n_tests++;
    if (buzzer_en !== 1'b0 || snooze_cnt !== 2'd1 || armed !== 1'b1) begin
      n_fail++; $display("FAIL snooze_enter: got buz=%0b scnt=%0d armed=%0b expected 0 1 1", buzzer_en, snooze_cnt, armed);
    end
    tick_once();
    n_tests++;
    if (blink !== 1'b1 || buzzer_en !== 1'b0) begin
      n_fail++; $display("FAIL snooze_tick1: got blink=%0b buz=%0b expected 1 0", blink, buzzer_en);
    end
    step(); tick_once();
    n_tests++;
    if (blink !== 1'b0 || buzzer_en !== 1'b0) begin
      n_fail++; $display("FAIL snooze_tick2: got blink=%0b buz=%0b expected 0 0", blink, buzzer_en);
    end
    step(); tick_once();
    n_tests++;
    if (blink !== 1'b1 || buzzer_en !== 1'b1) begin
      n_fail++; $display("FAIL snooze_rering: got blink=%0b buz=%0b expected 1 1", blink, buzzer_en);
    end
  endtask

  task automatic test_snooze_limit();
    for (int k = 0; k < 2; k++) begin
      snooze = 1'b1; step(); pulses_off();
      n_tests++;
      if (snooze_cnt !== 2'(k + 2) || buzzer_en !== 1'b0) begin
        n_fail++; $display("FAIL snooze_count%0d: got scnt=%0d buz=%0b expected %0d 0", k, snooze_cnt, buzzer_en, k + 2);
      end
      for (int t = 0; t < SNZ_SEC; t++) begin tick_once(); step(); end
    end
    snooze = 1'b1; step(); pulses_off();
    n_tests++;
    if (buzzer_en !== 1'b1 || snooze_cnt !== 2'd3) begin
      n_fail++; $display("FAIL snooze_max_ignored: got buz=%0b scnt=%0d expected 1 3", buzzer_en, snooze_cnt);
    end
    for (int t = 0; t < RING_SEC - 1; t++) begin tick_once(); step(); end
    n_tests++;
    if (buzzer_en !== 1'b1) begin
      n_fail++; $display("FAIL pre_timeout: got buz=%0b expected 1", buzzer_en);
    end
    tick_once();
    n_tests++;
    if (buzzer_en !== 1'b0 || armed !== 1'b1 || snooze_cnt !== 2'd0 || blink !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got buz=%0b armed=%0b scnt=%0d blink=%0b expected 0 1 0 0",
                         buzzer_en, armed, snooze_cnt, blink);
    end
  endtask

  task automatic test_priorities();
    cur_time = 11'd421; step();
    cur_time = 11'd420; step();
    n_tests++;
    if (buzzer_en !== 1'b1) begin
      n_fail++; $display("FAIL reRing: got buz=%0b expected 1", buzzer_en);
    end
    stop = 1'b1; snooze = 1'b1; step(); pulses_off();
    n_tests++;
    if (buzzer_en !== 1'b0 || armed !== 1'b1 || snooze_cnt !== 2'd0) begin
      n_fail++; $display("FAIL stop_beats_snooze: got buz=%0b armed=%0b scnt=%0d expected 0 1 0", buzzer_en, armed, snooze_cnt);
    end
    cur_time = 11'd421; step();
    arm = 1'b0; cur_time = 11'd420; step();
    n_tests++;
    if (armed !== 1'b0 || buzzer_en !== 1'b0) begin
      n_fail++; $display("FAIL disarm_beats_trigger: got armed=%0b buz=%0b expected 0 0", armed, buzzer_en);
    end
    step();
    n_tests++;
    if (buzzer_en !== 1'b0) begin
      n_fail++; $display("FAIL disarm_hold: got buz=%0b expected 0", buzzer_en);
    end
  endtask

  task automatic test_no_retrigger();
    logic [10:0] walk [6];
    walk = '{11'd421, 11'd1000, 11'd1439, 11'd0, 11'd419, 11'd420};
    arm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (buzzer_en !== 1'b0 || armed !== 1'b1) begin
        n_fail++; $display("FAIL arm_at_alarm_minute%0d: got buz=%0b armed=%0b expected 0 1", i, buzzer_en, armed);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cur_time = walk[i]; step();
      n_tests++;
      if (buzzer_en !== ((i == 5) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL next_day_walk%0d: got buz=%0b expected %0b", i, buzzer_en, (i == 5));
      end
    end
    stop = 1'b1; step(); pulses_off();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (buzzer_en !== 1'b0) begin
        n_fail++; $display("FAIL hold_after_stop%0d: got buz=%0b expected 0", i, buzzer_en);
      end
    end
  endtask

  task automatic test_reset_in_snooze();
    cur_time = 11'd421; step();
    cur_time = 11'd420; step();
    snooze = 1'b1; step(); pulses_off();
    tick_once();
    n_tests++;
    if (buzzer_en !== 1'b0 || snooze_cnt !== 2'd1 || blink !== 1'b1) begin
      n_fail++; $display("FAIL reach_snooze: got buz=%0b scnt=%0d blink=%0b expected 0 1 1", buzzer_en, snooze_cnt, blink);
    end
    reset = 1'b1; step();
    n_tests++;
    if ({alarm_time, buzzer_en, blink, armed, snooze_cnt, set_err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_in_snooze: got alarm=%0d buz=%0b blink=%0b armed=%0b scnt=%0d err=%0b, expected all 0",
               alarm_time, buzzer_en, blink, armed, snooze_cnt, set_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    reset = 1'b1; pulses_off(); arm = 1'b0; cur_time = 11'd0; step();
    reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 249) == 0);
      arm       = ($urandom_range(0, 59) != 0);
      tick      = 1'($urandom_range(0, 1));
      snooze    = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      set_valid = ($urandom_range(0, 24) == 0);
      set_time  = ($urandom_range(0, 9) == 0) ? 11'd1500 : 11'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) cur_time = 11'($urandom_range(0, 7));
      step();
      n_tests++;
      if (alarm_time !== 11'(m_alarm)) begin
        n_fail++; $display("FAIL rnd_alarm_time c=%0d: got %0d expected %0d", c, alarm_time, m_alarm);
      end
      n_tests++;
      if (buzzer_en !== (m_mode == M_RING)) begin
        n_fail++; $display("FAIL rnd_buzzer c=%0d: got %0b expected %0b", c, buzzer_en, (m_mode == M_RING));
      end
      n_tests++;
      if (armed !== (m_mode != M_OFF)) begin
        n_fail++; $display("FAIL rnd_armed c=%0d: got %0b expected %0b", c, armed, (m_mode != M_OFF));
      end
      n_tests++;
      if (blink !== m_blink) begin
        n_fail++; $display("FAIL rnd_blink c=%0d: got %0b expected %0b", c, blink, m_blink);
      end
      n_tests++;
      if (snooze_cnt !== 2'(m_scnt)) begin
        n_fail++; $display("FAIL rnd_snooze_cnt c=%0d: got %0d expected %0d", c, snooze_cnt, m_scnt);
      end
      n_tests++;
      if (set_err !== m_serr) begin
        n_fail++; $display("FAIL rnd_set_err c=%0d: got %0b expected %0b", c, set_err, m_serr);
      end
    end
    reset = 1'b0; pulses_off();
  endtask

  initial begin
    test_reset();
    test_set_and_arm();
    test_snooze_cycle();
    test_snooze_limit();
    test_priorities();
    test_no_retrigger();
    test_reset_in_snooze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
